alu_operand_entry: RTL and testbench

Sequential operand-entry front end for the 4-bit ALU. It synchronizes and debounces an ENTER and a CLEAR pushbutton, then steps through A, B and opcode capture from the switch nibble. It presents the latched operands to the ALU under a valid/ready handshake and holds the returned result for the seven-segment display path. It is the input-side counterpart to the display path: switches and buttons come in, registered operands and a stable result go out.

---
 rtl/alu_operand_entry.sv | 202 ++++++++++++++++++++
 tb/tb_alu_operand_entry.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_entry.sv
// alu_operand_entry: operand-entry front end for the 4-bit ALU.
// Two raw pushbuttons (ENTER, CLEAR) are synchronized and debounced into
// single-cycle rising-edge pulses. An FSM steps through A, B and opcode
// capture from the switch nibble. It offers the operands to the ALU under a
// valid/ready handshake and holds the returned result for the display.
// Optional feature macro: ALU_ENTRY_CHAIN_EN. When it is defined, ENTER in
// SHOW loads the held result into A and resumes at B entry.

module alu_entry_debounce #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Synchronize the button, then accept a new level only after it has
    // differed from the accepted level for CYCLES consecutive samples.
    // The rise pulse is registered when the level flips 0 -> 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
                rise  <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module alu_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESET,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic [3:0] sw_data,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       M,
    output logic [1:0] alu_op,
    output logic       op_valid,
    input  logic       op_ready,
    input  logic [3:0] alu_result,
    output logic [3:0] result_q,
    output logic [2:0] stage,
    output logic       result_valid
);
    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    state_t state, state_n;

    // Button index 0 = ENTER, 1 = CLEAR; both share one debouncer design.
    logic [1:0] btn_raw;
    logic [1:0] btn_p;
    logic       enter_p;
    logic       clear_p;

    assign btn_raw = {btn_clear, btn_enter};
    assign enter_p = btn_p[0];
    assign clear_p = btn_p[1];

    for (genvar i = 0; i < 2; i++) begin : g_btn
        alu_entry_debounce #(
            .CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (CLK100MHZ),
            .rst  (CPU_RESET),
            .raw  (btn_raw[i]),
            .rise (btn_p[i])
        );
    end

    logic load_a;
    logic load_b;
    logic load_op;
    logic cap_res;
    logic drop_res;
    logic chain_a;
    logic clr;

    // Next-state and register-load strobes. Clear outranks everything, so a
    // coincident ENTER is discarded. ENTER has no effect in EXEC, which keeps
    // the operands frozen while the request is outstanding.
    always_comb begin
        state_n  = state;
        load_a   = 1'b0;
        load_b   = 1'b0;
        load_op  = 1'b0;
        cap_res  = 1'b0;
        drop_res = 1'b0;
        chain_a  = 1'b0;
        clr      = 1'b0;
        if (clear_p) begin
            clr     = 1'b1;
            state_n = GET_A;
        end else begin
            case (state)
                GET_A: if (enter_p) begin
                    load_a  = 1'b1;
                    state_n = GET_B;
                end
                GET_B: if (enter_p) begin
                    load_b  = 1'b1;
                    state_n = GET_OP;
                end
                GET_OP: if (enter_p) begin
                    load_op = 1'b1;
                    state_n = EXEC;
                end
                EXEC: if (op_ready) begin
                    cap_res = 1'b1;
                    state_n = SHOW;
                end
                SHOW: if (enter_p) begin
                    drop_res = 1'b1;
`ifdef ALU_ENTRY_CHAIN_EN
                    chain_a  = 1'b1;
                    state_n  = GET_B;
`else
                    state_n  = GET_A;
`endif
                end
                default: state_n = GET_A;
            endcase
        end
    end

    // State and datapath registers, all cleared by reset or a CLEAR pulse.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            state        <= GET_A;
            a            <= 4'h0;
            b            <= 4'h0;
            M            <= 1'b0;
            alu_op       <= 2'b00;
            result_q     <= 4'h0;
            result_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (clr) begin
                a            <= 4'h0;
                b            <= 4'h0;
                M            <= 1'b0;
                alu_op       <= 2'b00;
                result_q     <= 4'h0;
                result_valid <= 1'b0;
            end else begin
                if (load_a)  a <= sw_data;
                if (chain_a) a <= result_q;
                if (load_b)  b <= sw_data;
                if (load_op) begin
                    M      <= sw_data[2];
                    alu_op <= sw_data[1:0];
                end
                if (cap_res) begin
                    result_q     <= alu_result;
                    result_valid <= 1'b1;
                end
                if (drop_res) result_valid <= 1'b0;
            end
        end
    end

    // Request is outstanding exactly while in EXEC.
    assign op_valid = (state == EXEC);

    // One-hot stage indicator for the display.
    always_comb begin
        stage = 3'b000;
        case (state)
            GET_A:   stage = 3'b001;
            GET_B:   stage = 3'b010;
            GET_OP:  stage = 3'b100;
            default: stage = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_alu_operand_entry.sv
// Self-checking bench for alu_operand_entry with DEBOUNCE_CYCLES = 4.
// A small ALU stand-in drives alu_result; expected results are queued when
// operands are entered and popped when result_valid rises.

module tb_alu_operand_entry;
    logic       CLK100MHZ = 1'b0;
    logic       CPU_RESET;
    logic       btn_enter;
    logic       btn_clear;
    logic [3:0] sw_data;
    logic [3:0] a;
    logic [3:0] b;
    logic       M;
    logic [1:0] alu_op;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] alu_result;
    logic [3:0] result_q;
    logic [2:0] stage;
    logic       result_valid;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        logic [1:0] op;
        logic [3:0] res;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total = 0;

    // Monitor bookkeeping (recording only).
    int   cyc = 0;
    int   ov_cnt = 0;
    int   ov_rise = 0;
    int   rv_rise = 0;
    logic ov_prev = 1'b0;
    logic rv_prev = 1'b0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    function automatic logic [3:0] alu_model(input logic [3:0] x, input logic [3:0] y,
                                             input logic m, input logic [1:0] op);
        logic [3:0] r;
        case (op)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x + y;
            default: r = x - y;
        endcase
        return m ? ~r : r;
    endfunction

    assign alu_result = alu_model(a, b, M, alu_op);

    alu_operand_entry #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK100MHZ    (CLK100MHZ),
        .CPU_RESET    (CPU_RESET),
        .btn_enter    (btn_enter),
        .btn_clear    (btn_clear),
        .sw_data      (sw_data),
        .a            (a),
        .b            (b),
        .M            (M),
        .alu_op       (alu_op),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .alu_result   (alu_result),
        .result_q     (result_q),
        .stage        (stage),
        .result_valid (result_valid)
    );

    always @(negedge CLK100MHZ) begin
        cyc++;
        if (op_valid === 1'b1) ov_cnt++;
        if (op_valid === 1'b1 && ov_prev !== 1'b1) ov_rise = cyc;
        if (result_valid === 1'b1 && rv_prev !== 1'b1) rv_rise = cyc;
        ov_prev = op_valid;
        rv_prev = result_valid;
    end

    // Press one or both buttons with a given switch value, then release and
    // let the release debounce out. Ends on a falling edge.
    task automatic press(input logic en, input logic cl, input logic [3:0] sw, input int hold);
        @(negedge CLK100MHZ);
        sw_data   = sw;
        btn_enter = en;
        btn_clear = cl;
        repeat (hold) @(negedge CLK100MHZ);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (10) @(negedge CLK100MHZ);
    endtask

    task automatic wait_rv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (result_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK100MHZ);
        end
    endtask

    task automatic test_reset();
        CPU_RESET = 1'b1;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        sw_data   = 4'h0;
        op_ready  = 1'b1;
        repeat (3) @(negedge CLK100MHZ);
        CPU_RESET = 1'b0;
        @(negedge CLK100MHZ);
        total++;
        if ({a, b, M, alu_op, result_q} !== 15'h0)
            $display("FAIL reset_regs got a=%h b=%h M=%b op=%b res=%h want all 0", a, b, M, alu_op, result_q);
        else pass_cnt++;
        total++;
        if (stage !== 3'b001 || op_valid !== 1'b0 || result_valid !== 1'b0)
            $display("FAIL reset_ctrl got stage=%b ov=%b rv=%b want 001/0/0", stage, op_valid, result_valid);
        else pass_cnt++;
    endtask

    task automatic test_full_entry();
        exp_t e;
        bit   ok;
        press(1'b1, 1'b0, 4'h3, 8);
        total++;
        if (a !== 4'h3 || stage !== 3'b010) $display("FAIL cap_a got a=%h stage=%b want 3/010", a, stage);
        else pass_cnt++;
        press(1'b1, 1'b0, 4'h5, 8);
        total++;
        if (b !== 4'h5 || stage !== 3'b100) $display("FAIL cap_b got b=%h stage=%b want 5/100", b, stage);
        else pass_cnt++;
        ov_cnt = 0;
        sb.push_back('{a: 4'h3, b: 4'h5, m: 1'b0, op: 2'b10, res: 4'h8});
        press(1'b1, 1'b0, 4'b0010, 8);
        wait_rv(ok);
        total++;
        if (!ok) $display("FAIL full_timeout got result_valid=%b want 1", result_valid);
        else begin
            e = sb.pop_front();
            if ({a, b, M, alu_op, result_q} !== {e.a, e.b, e.m, e.op, e.res})
                $display("FAIL full_result got a=%h b=%h M=%b op=%b res=%h want %h %h %b %b %h",
                         a, b, M, alu_op, result_q, e.a, e.b, e.m, e.op, e.res);
            else pass_cnt++;
        end
        total++;
        if (ov_cnt !== 1) $display("FAIL op_valid_len got %0d cycles want 1", ov_cnt);
        else pass_cnt++;
        total++;
        if (rv_rise - ov_rise !== 1) $display("FAIL result_latency got %0d want 1 after op_valid", rv_rise - ov_rise);
        else pass_cnt++;
        total++;
        if (stage !== 3'b000 || op_valid !== 1'b0) $display("FAIL show_state got stage=%b ov=%b want 000/0", stage, op_valid);
        else pass_cnt++;
    endtask

    task automatic test_show_exit();
        press(1'b1, 1'b0, 4'hE, 8);
`ifdef ALU_ENTRY_CHAIN_EN
        total++;
        if (a !== 4'h8 || stage !== 3'b010 || result_valid !== 1'b0)
            $display("FAIL chain got a=%h stage=%b rv=%b want 8/010/0", a, stage, result_valid);
        else pass_cnt++;
        press(1'b0, 1'b1, 4'h0, 8);
`else
        total++;
        if (stage !== 3'b001 || result_valid !== 1'b0 || a !== 4'h3 || result_q !== 4'h8)
            $display("FAIL show_exit got stage=%b rv=%b a=%h res=%h want 001/0/3/8", stage, result_valid, a, result_q);
        else pass_cnt++;
`endif
    endtask

    task automatic test_debounce();
        logic [3:0] a_before;
        a_before = a;
        press(1'b1, 1'b0, 4'h9, 3);
        total++;
        if (stage !== 3'b001 || a !== a_before)
            $display("FAIL glitch got stage=%b a=%h want 001/%h", stage, a, a_before);
        else pass_cnt++;
        press(1'b1, 1'b0, 4'h6, 6);
        total++;
        if (stage !== 3'b010 || a !== 4'h6)
            $display("FAIL one_capture got stage=%b a=%h want 010/6", stage, a);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        exp_t e;
        bit   ok;
        press(1'b1, 1'b0, 4'h4, 8);
        op_ready = 1'b0;
        sb.push_back('{a: 4'h6, b: 4'h4, m: 1'b0, op: 2'b01, res: alu_model(4'h6, 4'h4, 1'b0, 2'b01)});
        press(1'b1, 1'b0, 4'b1001, 8);
        total++;
        if (op_valid !== 1'b1 || M !== 1'b0 || alu_op !== 2'b01)
            $display("FAIL stall_req got ov=%b M=%b op=%b want 1/0/01", op_valid, M, alu_op);
        else pass_cnt++;
        press(1'b1, 1'b0, 4'hF, 8);
        total++;
        if (op_valid !== 1'b1 || stage !== 3'b000 || a !== 4'h6 || b !== 4'h4 || result_valid !== 1'b0)
            $display("FAIL stall_hold got ov=%b stage=%b a=%h b=%h rv=%b want 1/000/6/4/0",
                     op_valid, stage, a, b, result_valid);
        else pass_cnt++;
        op_ready = 1'b1;
        @(negedge CLK100MHZ);
        total++;
        if (result_valid !== 1'b1 || op_valid !== 1'b0)
            $display("FAIL stall_release got rv=%b ov=%b want 1/0", result_valid, op_valid);
        else pass_cnt++;
        wait_rv(ok);
        total++;
        if (!ok) $display("FAIL stall_timeout got result_valid=%b want 1", result_valid);
        else begin
            e = sb.pop_front();
            if (result_q !== e.res) $display("FAIL stall_result got %h want %h", result_q, e.res);
            else pass_cnt++;
        end
        press(1'b0, 1'b1, 4'h0, 8);
        total++;
        if (stage !== 3'b001 || result_q !== 4'h0 || result_valid !== 1'b0)
            $display("FAIL clear_show got stage=%b res=%h rv=%b want 001/0/0", stage, result_q, result_valid);
        else pass_cnt++;
    endtask

    task automatic test_clear_priority();
        press(1'b1, 1'b0, 4'h7, 8);
        total++;
        if (a !== 4'h7 || stage !== 3'b010) $display("FAIL pre_clear got a=%h stage=%b want 7/010", a, stage);
        else pass_cnt++;
        press(1'b1, 1'b1, 4'hA, 8);
        total++;
        if (a !== 4'h0 || b !== 4'h0 || stage !== 3'b001)
            $display("FAIL clear_prio got a=%h b=%h stage=%b want 0/0/001", a, b, stage);
        else pass_cnt++;
    endtask

    task automatic test_reset_exec();
        op_ready = 1'b0;
        press(1'b1, 1'b0, 4'h1, 8);
        press(1'b1, 1'b0, 4'h2, 8);
        press(1'b1, 1'b0, 4'b0111, 8);
        total++;
        if (op_valid !== 1'b1 || M !== 1'b1 || alu_op !== 2'b11)
            $display("FAIL exec_pre got ov=%b M=%b op=%b want 1/1/11", op_valid, M, alu_op);
        else pass_cnt++;
        CPU_RESET = 1'b1;
        @(negedge CLK100MHZ);
        CPU_RESET = 1'b0;
        op_ready  = 1'b1;
        total++;
        if (op_valid !== 1'b0 || result_valid !== 1'b0 || stage !== 3'b001 ||
            {a, b, M, alu_op, result_q} !== 15'h0)
            $display("FAIL reset_exec got ov=%b rv=%b stage=%b a=%h b=%h res=%h want 0/0/001/0/0/0",
                     op_valid, result_valid, stage, a, b, result_q);
        else pass_cnt++;
        repeat (3) @(negedge CLK100MHZ);
        total++;
        if (result_valid !== 1'b0 || op_valid !== 1'b0)
            $display("FAIL reset_exec_after got rv=%b ov=%b want 0/0", result_valid, op_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        press(1'b1, 1'b0, 4'hC, 8);
        press(1'b1, 1'b0, 4'hA, 8);
        sb.push_back('{a: 4'hC, b: 4'hA, m: 1'b1, op: 2'b00, res: alu_model(4'hC, 4'hA, 1'b1, 2'b00)});
        press(1'b1, 1'b0, 4'b1100, 8);
        wait_rv(ok);
        total++;
        if (!ok) $display("FAIL b2b_timeout got result_valid=%b want 1", result_valid);
        else begin
            e = sb.pop_front();
            if (result_q !== e.res || M !== e.m || alu_op !== e.op)
                $display("FAIL b2b_result got res=%h M=%b op=%b want %h %b %b", result_q, M, alu_op, e.res, e.m, e.op);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_full_entry();
        test_show_exit();
        test_debounce();
        test_stall();
        test_clear_priority();
        test_reset_exec();
        test_back_to_back();
        total++;
        if (sb.size() !== 0) $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
